param_ram_card: RTL and testbench
=================================

PARAM_RAM_CARD -- requirements
Module: param_ram_card

Interface
REQ-001 Parameter DATAWIDTH, default `DATAWIDTH, width of data and address buses.
REQ-002 Parameter CTRLWIDTH, default `CTRLWIDTH, width of the control bus.
REQ-003 Parameter RAMBASE, default 0, first bus address decoded by this card.
REQ-004 Parameter RAMSIZE, default 512, number of words, power of two, at most 2^(DATAWIDTH-1).
REQ-005 Parameter WAIT_CYCLES, default 0, extra access wait states, range 0-15.
REQ-006 Port clk, input, 1, single clock; all state changes on its rising edge.
REQ-007 Port rst_n, input, 1, reset, asynchronous, active-low.
REQ-008 Port data, inout, DATAWIDTH, shared data bus.
REQ-009 Port addr, input, DATAWIDTH, shared address bus.
REQ-010 Port ctrl, inout, CTRLWIDTH, control bus; uses `CTRL_RD_REQ, `CTRL_WR_REQ, `CTRL_RD_READY, `CTRL_WR_DONE.

Function
REQ-011 Card selected: addr in RAMBASE..RAMBASE+RAMSIZE-1 inclusive; word index = addr-RAMBASE, truncated to log2(RAMSIZE) bits.
REQ-012 rd_sel = `CTRL_RD_REQ AND selected; wr_sel = `CTRL_WR_REQ AND selected; both high -> read serviced, write ignored.
REQ-013 FSM states: IDLE, WAIT, RESP.
REQ-014 IDLE, rd_sel or wr_sel at edge k: latch op, index, write data; load counter = WAIT_CYCLES; go WAIT.
REQ-015 WAIT, counter nonzero: decrement. Counter zero: perform access (read into result register, or write array), go RESP.
REQ-016 RESP: `CTRL_RD_READY or `CTRL_WR_DONE = 1 (registered); held until the request drops, then IDLE on next edge.
REQ-017 Latency: ready/done high after edge k+1+WAIT_CYCLES; WAIT_CYCLES=0 gives 2-cycle response.
REQ-018 Request dropped or address leaves window in WAIT: abort to IDLE next edge; no array write; ready/done never asserted.
REQ-019 Back-to-back: new request accepted only from IDLE; at least one IDLE cycle between transactions.
REQ-020 data driven with result register only in RESP with latched op = read and rd_sel high; otherwise Z.
REQ-021 `CTRL_RD_READY driven (0/1) only while rd_sel high, `CTRL_WR_DONE only while wr_sel high; Z otherwise.
REQ-022 Unselected cycles: card drives nothing, FSM stays IDLE.

Reset
REQ-023 rst_n low: immediately FSM IDLE, counter 0, ready/done registers 0, result register 0, all bus outputs Z.
REQ-024 Reset during WAIT: pending write discarded; array contents never cleared by reset.
REQ-025 rst_n release: first request accepted at first rising edge with rst_n high.

Configuration
REQ-026 Macro RAM_CARD_WRPROT_EN: defined -> parameter WRPROT_WORDS (default 16) protects indices 0..WRPROT_WORDS-1; such writes complete handshake normally, array unchanged.
REQ-027 Macro RAM_CARD_WRPROT_EN undefined -> no protection logic, all indices writable, WRPROT_WORDS absent.

Structure
REQ-028 Shared src/config.v holds DATAWIDTH, CTRLWIDTH, CTRL_* bit indices; no new ctrl bits added.
REQ-029 Storage in sub-module ram_card_array (synchronous one-port, DATAWIDTH x RAMSIZE); FSM, decode, tri-state in param_ram_card.

Verification
REQ-030 RAMBASE=0x100, WAIT_CYCLES=0: write 0xBEEF to 0x105, drop WR_REQ, read 0x105 -> WR_DONE at k+1, RD_READY at k+1, data=0xBEEF.
REQ-031 WAIT_CYCLES=3: read request at edge k -> RD_READY low through k+3, high after k+4, held until RD_REQ drops, IDLE next edge.
REQ-032 Address 0x0FF and 0x100+RAMSIZE with RD_REQ -> data, RD_READY, WR_DONE stay Z, FSM stays IDLE.
REQ-033 WAIT_CYCLES=2: write 0x1234 to 0x101, drop WR_REQ after 1 cycle -> no WR_DONE; later read returns prior value.
REQ-034 rst_n low mid-WAIT of write 0x5555 -> outputs Z immediately; after release read returns old value, RD_READY latency normal.
REQ-035 RAM_CARD_WRPROT_EN, WRPROT_WORDS=16: write 0xAAAA to index 3 -> WR_DONE asserted, read returns old value; index 16 write succeeds.

Source files
------------

// File: rtl/param_ram_card_pkg.sv
// rtl/param_ram_card_pkg.sv - shared bus widths, control bit indices and FSM state type for the RAM card
// Bus-wide defines live here so every card on the bus agrees on ctrl bit positions.
`ifndef DATAWIDTH
`define DATAWIDTH 16
`endif
`ifndef CTRLWIDTH
`define CTRLWIDTH 4
`endif
`ifndef CTRL_RD_REQ
`define CTRL_RD_REQ 0
`endif
`ifndef CTRL_WR_REQ
`define CTRL_WR_REQ 1
`endif
`ifndef CTRL_RD_READY
`define CTRL_RD_READY 2
`endif
`ifndef CTRL_WR_DONE
`define CTRL_WR_DONE 3
`endif

package param_ram_card_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/ram_card_array.sv
// rtl/ram_card_array.sv - single-port synchronous word store with a resettable read result register
module ram_card_array #(
    parameter int DW    = 16,
    parameter int DEPTH = 512,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_we,
    input  logic             i_re,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [DW-1:0]    i_wdata,
    output logic [DW-1:0]    o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    // Storage is deliberately outside the reset domain: contents survive rst_n.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/param_ram_card.sv
// rtl/param_ram_card.sv - bus RAM card: window decode, wait-state FSM and tri-state bus drivers
// Define RAM_CARD_WRPROT_EN to make indices 0..WRPROT_WORDS-1 read-only.
module param_ram_card
    import param_ram_card_pkg::*;
#(
    parameter int DATAWIDTH   = `DATAWIDTH,
    parameter int CTRLWIDTH   = `CTRLWIDTH,
    parameter int RAMBASE     = 0,
    parameter int RAMSIZE     = 512,
    parameter int WAIT_CYCLES = 0
`ifdef RAM_CARD_WRPROT_EN
    ,
    parameter int WRPROT_WORDS = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    inout  wire  [DATAWIDTH-1:0] data,
    input  logic [DATAWIDTH-1:0] addr,
    inout  wire  [CTRLWIDTH-1:0] ctrl
);

    localparam int                 IDX_W   = $clog2(RAMSIZE);
    localparam logic [DATAWIDTH:0] BASE_X  = (DATAWIDTH + 1)'(RAMBASE);
    localparam logic [DATAWIDTH:0] SIZE_X  = (DATAWIDTH + 1)'(RAMSIZE);
    localparam logic [CNT_W-1:0]   WAIT_LD = CNT_W'(WAIT_CYCLES);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_op_rd;
    logic [IDX_W-1:0]     r_idx;
    logic [DATAWIDTH-1:0] r_wdata;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_rdy;
    logic                 r_done;

    logic [DATAWIDTH:0]   w_off;
    logic                 w_sel;
    logic                 w_rd_sel;
    logic                 w_wr_sel;
    logic                 w_req_held;
    logic                 w_access;
    logic                 w_prot;
    logic                 w_we;
    logic                 w_re;
    logic [DATAWIDTH-1:0] w_rdata;
    logic [CTRLWIDTH-1:0] w_ctrl_o;
    logic [CTRLWIDTH-1:0] w_ctrl_oe;
    logic                 w_unused_ctrl;

    // One extra bit so an address below RAMBASE shows up as a borrow in the MSB.
    assign w_off      = {1'b0, addr} - BASE_X;
    assign w_sel      = !w_off[DATAWIDTH] && (w_off < SIZE_X);
    assign w_rd_sel   = ctrl[`CTRL_RD_REQ] & w_sel;
    assign w_wr_sel   = ctrl[`CTRL_WR_REQ] & w_sel;
    assign w_req_held = r_op_rd ? w_rd_sel : w_wr_sel;

    always_comb begin
        w_state_nxt = r_state;
        w_access    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rd_sel || w_wr_sel) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!w_req_held) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == '0) begin
                    w_state_nxt = ST_RESP;
                    w_access    = 1'b1;
                end
            end
            ST_RESP: begin
                if (!w_req_held) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_op_rd <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
            r_rdy   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rdy   <= (w_state_nxt == ST_RESP) && r_op_rd;
            r_done  <= (w_state_nxt == ST_RESP) && !r_op_rd;
            if (r_state == ST_IDLE && w_state_nxt == ST_WAIT) begin
                r_op_rd <= w_rd_sel;
                r_idx   <= w_off[IDX_W-1:0];
                r_wdata <= data;
                r_cnt   <= WAIT_LD;
            end else if (r_state == ST_WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

`ifdef RAM_CARD_WRPROT_EN
    assign w_prot = (32'(r_idx) < 32'(WRPROT_WORDS));
`else
    assign w_prot = 1'b0;
`endif

    assign w_we = w_access && !r_op_rd && !w_prot;
    assign w_re = w_access && r_op_rd;

    ram_card_array #(
        .DW    (DATAWIDTH),
        .DEPTH (RAMSIZE),
        .IDX_W (IDX_W)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_idx   (r_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

    assign data = (rst_n && r_state == ST_RESP && r_op_rd && w_rd_sel) ? w_rdata : 'z;

    // Handshake bits are owned only while the matching request targets this card.
    always_comb begin
        w_ctrl_o                  = '0;
        w_ctrl_oe                 = '0;
        w_ctrl_o[`CTRL_RD_READY]  = r_rdy;
        w_ctrl_oe[`CTRL_RD_READY] = rst_n && w_rd_sel;
        w_ctrl_o[`CTRL_WR_DONE]   = r_done;
        w_ctrl_oe[`CTRL_WR_DONE]  = rst_n && w_wr_sel;
    end

    for (genvar gi = 0; gi < CTRLWIDTH; gi++) begin : g_ctrl
        assign ctrl[gi] = w_ctrl_oe[gi] ? w_ctrl_o[gi] : 1'bz;
    end

    assign w_unused_ctrl = ^ctrl;

endmodule

// File: tb/tb_param_ram_card.sv
// tb/tb_param_ram_card.sv - directed vector bench for param_ram_card (zero-wait and three-wait instances)
module tb_param_ram_card;

    localparam int          DW = `DATAWIDTH;
    localparam int          CW = `CTRLWIDTH;
    localparam logic [15:0] ZD = 16'hFFFF;
`ifdef RAM_CARD_WRPROT_EN
    localparam logic [15:0] A_B = 16'h0125;
`else
    localparam logic [15:0] A_B = 16'h0105;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] a0, a3, wd0, wd3;
    logic          rd0, wr0, drv0, rd3, wr3, drv3;

    // Pull-ups make an undriven bus read as all ones.
    tri1 [DW-1:0] d0, d3;
    tri1 [CW-1:0] c0, c3;

    assign d0              = drv0 ? wd0 : 'z;
    assign d3              = drv3 ? wd3 : 'z;
    assign c0[`CTRL_RD_REQ] = rd0;
    assign c0[`CTRL_WR_REQ] = wr0;
    assign c3[`CTRL_RD_REQ] = rd3;
    assign c3[`CTRL_WR_REQ] = wr3;

    param_ram_card #(.RAMBASE(32'h100), .RAMSIZE(512), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .data(d0), .addr(a0), .ctrl(c0)
    );
    param_ram_card #(.RAMBASE(32'h100), .RAMSIZE(512), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .data(d3), .addr(a3), .ctrl(c3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr, drv;
        logic [15:0] addr, wd, exp_d;
        logic        exp_rdy, exp_done;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t v(input logic rd, wr, drv, input logic [15:0] addr, wd, ed,
                               input logic er, edn);
        vec_t t;
        t.rd = rd; t.wr = wr; t.drv = drv; t.addr = addr; t.wd = wd;
        t.exp_d = ed; t.exp_rdy = er; t.exp_done = edn;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set0(input logic rd, wr, drv, input logic [15:0] addr, wd);
        rd0 = rd; wr0 = wr; drv0 = drv; a0 = addr; wd0 = wd;
    endtask

    task automatic set3(input logic rd, wr, drv, input logic [15:0] addr, wd);
        rd3 = rd; wr3 = wr; drv3 = drv; a3 = addr; wd3 = wd;
    endtask

    task automatic write3(input logic [15:0] addr, input logic [15:0] val);
        set3(0, 1, 1, addr, val);
        for (int n = 0; n < 16; n++) begin
            tick();
            if (c3[`CTRL_WR_DONE] === 1'b1) break;
        end
        chk("wr3_done", c3[`CTRL_WR_DONE], 1);
        set3(0, 0, 0, addr, 0);
        tick();
    endtask

    task automatic read3(input string nm, input logic [15:0] addr, input logic [15:0] exp);
        set3(1, 0, 0, addr, 0);
        for (int n = 0; n < 4; n++) begin
            tick();
            chk({nm, "_rdy_low"}, c3[`CTRL_RD_READY], 0);
        end
        tick();
        chk({nm, "_rdy_k4"}, c3[`CTRL_RD_READY], 1);
        chk({nm, "_data"}, d3, exp);
        tick();
        chk({nm, "_rdy_held"}, c3[`CTRL_RD_READY], 1);
        set3(0, 0, 0, addr, 0);
        tick();
        chk({nm, "_rdy_z"}, c3[`CTRL_RD_READY], 1);
        chk({nm, "_data_z"}, d3, ZD);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        set0(1, 0, 0, A_B, 0);
        set3(1, 0, 0, 16'h0141, 0);
        @(negedge clk);
        chk("rst_rdy0_z", c0[`CTRL_RD_READY], 1);
        chk("rst_done0_z", c0[`CTRL_WR_DONE], 1);
        chk("rst_data0_z", d0, ZD);
        chk("rst_rdy3_z", c3[`CTRL_RD_READY], 1);
        set0(0, 0, 0, A_B, 0);
        set3(0, 0, 0, 16'h0141, 0);
        rst_n = 1'b1;

        // rd, wr, drv, addr, wdata, exp data, exp rd_ready, exp wr_done  (Z reads as 1)
        tbl.push_back(v(0, 0, 0, A_B,     16'h0000, ZD,       1, 1));
        tbl.push_back(v(0, 1, 1, A_B,     16'hBEEF, 16'hBEEF, 1, 0));
        tbl.push_back(v(0, 1, 1, A_B,     16'hBEEF, 16'hBEEF, 1, 1));
        tbl.push_back(v(0, 0, 0, A_B,     16'h0000, ZD,       1, 1));
        tbl.push_back(v(0, 1, 1, 16'h120, 16'h0001, 16'h0001, 1, 0));
        tbl.push_back(v(0, 1, 1, 16'h120, 16'h0001, 16'h0001, 1, 1));
        tbl.push_back(v(0, 0, 0, 16'h120, 16'h0000, ZD,       1, 1));
        tbl.push_back(v(0, 1, 1, 16'h2FF, 16'h1357, 16'h1357, 1, 0));
        tbl.push_back(v(0, 1, 1, 16'h2FF, 16'h1357, 16'h1357, 1, 1));
        tbl.push_back(v(0, 0, 0, 16'h2FF, 16'h0000, ZD,       1, 1));
        tbl.push_back(v(1, 0, 0, A_B,     16'h0000, ZD,       0, 1));
        tbl.push_back(v(1, 0, 0, A_B,     16'h0000, 16'hBEEF, 1, 1));
        tbl.push_back(v(1, 0, 0, A_B,     16'h0000, 16'hBEEF, 1, 1));
        tbl.push_back(v(0, 0, 0, A_B,     16'h0000, ZD,       1, 1));
        tbl.push_back(v(1, 0, 0, 16'h0FF, 16'h0000, ZD,       1, 1));
        tbl.push_back(v(1, 0, 0, 16'h300, 16'h0000, ZD,       1, 1));
        tbl.push_back(v(1, 0, 0, 16'h2FF, 16'h0000, ZD,       0, 1));
        tbl.push_back(v(1, 0, 0, 16'h2FF, 16'h0000, 16'h1357, 1, 1));
        tbl.push_back(v(0, 0, 0, 16'h2FF, 16'h0000, ZD,       1, 1));
        tbl.push_back(v(1, 0, 0, 16'h120, 16'h0000, ZD,       0, 1));
        tbl.push_back(v(1, 0, 0, 16'h120, 16'h0000, 16'h0001, 1, 1));
        tbl.push_back(v(0, 0, 0, 16'h120, 16'h0000, ZD,       1, 1));
        tbl.push_back(v(1, 1, 0, A_B,     16'h0000, ZD,       0, 0));
        tbl.push_back(v(1, 1, 0, A_B,     16'h0000, 16'hBEEF, 1, 0));
        tbl.push_back(v(0, 0, 0, A_B,     16'h0000, ZD,       1, 1));
        tbl.push_back(v(1, 0, 0, A_B,     16'h0000, ZD,       0, 1));
        tbl.push_back(v(1, 0, 0, A_B,     16'h0000, 16'hBEEF, 1, 1));
        tbl.push_back(v(0, 0, 0, A_B,     16'h0000, ZD,       1, 1));
        tbl.push_back(v(0, 1, 1, 16'h0FF, 16'h2222, 16'h2222, 1, 1));
        tbl.push_back(v(0, 0, 0, 16'h0FF, 16'h0000, ZD,       1, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            set0(tbl[i].rd, tbl[i].wr, tbl[i].drv, tbl[i].addr, tbl[i].wd);
            tick();
            chk($sformatf("vec%0d_data", i), d0, tbl[i].exp_d);
            chk($sformatf("vec%0d_rdy", i), c0[`CTRL_RD_READY], tbl[i].exp_rdy);
            chk($sformatf("vec%0d_done", i), c0[`CTRL_WR_DONE], tbl[i].exp_done);
        end

        // Three wait states: latency, hold, and return to idle.
        write3(16'h0141, 16'h4321);
        read3("lat", 16'h0141, 16'h4321);
        set3(1, 0, 0, 16'h0141, 0);
        tick();
        chk("reaccept_wait", c3[`CTRL_RD_READY], 0);
        set3(0, 0, 0, 16'h0141, 0);
        tick();
        tick();

        // Write request dropped inside the wait window.
        set3(0, 1, 1, 16'h0141, 16'h1234);
        tick();
        chk("drop_done_low", c3[`CTRL_WR_DONE], 0);
        set3(0, 0, 0, 16'h0141, 0);
        tick();
        tick();
        read3("after_drop", 16'h0141, 16'h4321);

        // Address leaves the window inside the wait window.
        set3(0, 1, 1, 16'h0141, 16'h7777);
        tick();
        chk("leave_done_low", c3[`CTRL_WR_DONE], 0);
        a3 = 16'h00FF;
        repeat (6) tick();
        chk("leave_data_tb", d3, 16'h7777);
        set3(0, 0, 0, 16'h0141, 0);
        tick();
        read3("after_leave", 16'h0141, 16'h4321);

        // Reset in the middle of a pending write.
        set3(0, 1, 1, 16'h0141, 16'h5555);
        tick();
        tick();
        chk("prerst_done_low", c3[`CTRL_WR_DONE], 0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_done_z", c3[`CTRL_WR_DONE], 1);
        chk("rst_mid_rdy_z", c3[`CTRL_RD_READY], 1);
        set3(0, 0, 0, 16'h0141, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        read3("after_rst", 16'h0141, 16'h4321);

        set0(1, 0, 0, A_B, 0);
        tick();
        chk("rst_keep_rdy_low", c0[`CTRL_RD_READY], 0);
        tick();
        chk("rst_keep_data", d0, 16'hBEEF);
        set0(0, 0, 0, A_B, 0);
        tick();

`ifdef RAM_CARD_WRPROT_EN
        set0(0, 1, 1, 16'h0103, 16'hAAAA);
        tick();
        tick();
        chk("prot_done", c0[`CTRL_WR_DONE], 1);
        set0(0, 0, 0, 16'h0103, 0);
        tick();
        set0(1, 0, 0, 16'h0103, 0);
        tick();
        tick();
        total++;
        if (d0 === 16'hAAAA) begin
            bad++;
            $display("FAIL prot_idx3 got=%h want=not aaaa", d0);
        end
        set0(0, 0, 0, 16'h0110, 0);
        tick();
        set0(0, 1, 1, 16'h0110, 16'hAAAA);
        tick();
        tick();
        chk("unprot_done", c0[`CTRL_WR_DONE], 1);
        set0(0, 0, 0, 16'h0110, 0);
        tick();
        set0(1, 0, 0, 16'h0110, 0);
        tick();
        tick();
        chk("unprot_idx16", d0, 16'hAAAA);
        set0(0, 0, 0, 16'h0110, 0);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
